// File: rtl/gv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gv_pkg: shared state encoding, widths and BCD digit type for the game core.
// Rev 1.0
// ----------------------------------------------------------------------------
package gv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int MISS_W = 8;

  typedef logic [3:0] bcd_digit_t;

endpackage
`default_nettype wire

// File: rtl/bcd_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bcd_accum: multi-digit BCD accumulator, adds 0..9 per cycle, saturates at 9s.
// Rev 1.0
// ----------------------------------------------------------------------------
module bcd_accum
  import gv_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clr,
  input  logic [3:0]          add,
  output logic [4*DIGITS-1:0] bcd_o
);

  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] acc_d;
  logic [4:0]          cin_w;
  logic [4:0]          s_w;
  bcd_digit_t          dig_w;

  // Ripple through the digits; a carry out of the top digit means overflow.
  always_comb begin
    acc_d = '0;
    cin_w = {1'b0, add};
    s_w   = '0;
    dig_w = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s_w = {1'b0, acc_q[i*4 +: 4]} + cin_w;
      if (s_w > 5'd9) begin
        dig_w = 4'(s_w - 5'd10);
        cin_w = 5'd1;
      end else begin
        dig_w = s_w[3:0];
        cin_w = 5'd0;
      end
      acc_d[i*4 +: 4] = dig_w;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (cin_w[0]) begin
      acc_q <= {DIGITS{4'h9}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bcd_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/note_highway.sv
`default_nettype none
// ----------------------------------------------------------------------------
// note_highway: scrolls note lanes toward a strike cell, judges presses,
// keeps BCD score and miss count.  Rev 1.0
// ----------------------------------------------------------------------------
module note_highway
  import gv_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int LANE_LEN     = 7,
  parameter int TICK_DIV     = 12000000,
  parameter int MAX_MISSES   = 5,
  parameter int SCORE_DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic [NUM_LANES-1:0]          button,
  input  logic [NUM_LANES-1:0]          note_in,
  output logic                          note_req,
  output logic [NUM_LANES*LANE_LEN-1:0] lanes,
  output logic                          hit_flash,
  output logic                          miss_flash,
  output logic [4*SCORE_DIGITS-1:0]     score_bcd,
  output logic [7:0]                    misses,
  output logic                          game_over
);

  localparam int              CNT_W     = $clog2(TICK_DIV);
  localparam int              LW        = NUM_LANES * LANE_LEN;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  game_state_t          state_q;
  logic [LW-1:0]        lanes_q;
  logic [LW-1:0]        lanes_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_LANES-1:0] btn_q;
  logic                 hit_flash_q;
  logic                 miss_flash_q;
  logic [MISS_W-1:0]    misses_q;
  logic [MISS_W-1:0]    misses_d;
  logic [MISS_W:0]      miss_sum;

  logic                 play;
  logic                 tick;
  logic                 score_clr;
  logic [NUM_LANES-1:0] press;
  logic [NUM_LANES-1:0] strike;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] wrong;
  logic [NUM_LANES-1:0] drop;
  logic [3:0]           n_hit;
  logic [4:0]           n_miss;

  function automatic logic [4:0] popcnt(input logic [NUM_LANES-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      popcnt = popcnt + 5'(v[i]);
    end
  endfunction

  assign play  = (state_q == PLAY);
  assign tick  = play && (cnt_q == TICK_LAST);
  assign press = button & ~btn_q;

  always_comb begin
    strike = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      strike[l] = lanes_q[l*LANE_LEN + LANE_LEN - 1];
    end
  end

  // All judging uses the lane contents from before this cycle's shift.
  assign hit    = {NUM_LANES{play}} & press & strike;
  assign wrong  = {NUM_LANES{play}} & press & ~strike;
  assign drop   = {NUM_LANES{tick}} & strike & ~press;
  assign n_hit  = 4'(popcnt(hit));
  assign n_miss = popcnt(wrong) + popcnt(drop);

  // A hit clears the strike bit; on a tick that cleared bit simply shifts out.
  always_comb begin
    lanes_d = lanes_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (hit[l]) begin
        lanes_d[l*LANE_LEN + LANE_LEN - 1] = 1'b0;
      end
      if (tick) begin
        for (int i = LANE_LEN - 1; i > 0; i--) begin
          lanes_d[l*LANE_LEN + i] = lanes_q[l*LANE_LEN + i - 1];
        end
        lanes_d[l*LANE_LEN] = note_in[l];
      end
    end
  end

  assign miss_sum = {1'b0, misses_q} + (MISS_W+1)'(n_miss);
  assign misses_d = miss_sum[MISS_W] ? {MISS_W{1'b1}} : miss_sum[MISS_W-1:0];

  assign score_clr = !play && start;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      lanes_q      <= '0;
      cnt_q        <= '0;
      btn_q        <= '0;
      hit_flash_q  <= 1'b0;
      miss_flash_q <= 1'b0;
      misses_q     <= '0;
    end else begin
      btn_q <= button;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= PLAY;
            misses_q     <= '0;
            hit_flash_q  <= 1'b0;
            miss_flash_q <= 1'b0;
          end
        end
        PLAY: begin
          cnt_q    <= tick ? '0 : cnt_q + 1'b1;
          lanes_q  <= lanes_d;
          misses_q <= misses_d;
          if (|hit) begin
            hit_flash_q <= 1'b1;
          end else if (tick) begin
            hit_flash_q <= 1'b0;
          end
          if (|(wrong | drop)) begin
            miss_flash_q <= 1'b1;
          end else if (tick) begin
            miss_flash_q <= 1'b0;
          end
          if (misses_q >= MISS_W'(MAX_MISSES)) begin
            state_q <= OVER;
          end
        end
        OVER: begin
          if (start) begin
            state_q      <= PLAY;
            lanes_q      <= '0;
            cnt_q        <= '0;
            misses_q     <= '0;
            hit_flash_q  <= 1'b0;
            miss_flash_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bcd_accum #(
    .DIGITS(SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (score_clr),
    .add   (n_hit),
    .bcd_o (score_bcd)
  );

  assign note_req   = tick;
  assign lanes      = lanes_q;
  assign hit_flash  = hit_flash_q;
  assign miss_flash = miss_flash_q;
  assign misses     = misses_q;
  assign game_over  = (state_q == OVER);

endmodule
`default_nettype wire

// File: tb/tb_note_highway.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_note_highway: directed vector table plus hand sequences for note_highway.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_note_highway;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [1:0] button;
  logic [1:0] note_in;
  logic       note_req;
  logic [7:0] lanes;
  logic       hit_flash;
  logic       miss_flash;
  logic [7:0] score_bcd;
  logic [7:0] misses;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  note_highway #(
    .NUM_LANES   (2),
    .LANE_LEN    (4),
    .TICK_DIV    (4),
    .MAX_MISSES  (3),
    .SCORE_DIGITS(2)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .button    (button),
    .note_in   (note_in),
    .note_req  (note_req),
    .lanes     (lanes),
    .hit_flash (hit_flash),
    .miss_flash(miss_flash),
    .score_bcd (score_bcd),
    .misses    (misses),
    .game_over (game_over)
  );

  typedef struct {
    logic       start;
    logic [1:0] btn;
    logic [1:0] nin;
    logic [7:0] lanes;
    logic [7:0] score;
    logic [7:0] miss;
    logic       hf;
    logic       mf;
    logic       req;
    logic       go;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic s, input logic [1:0] b, input logic [1:0] n,
                              input logic [7:0] ln, input logic [7:0] sc, input logic [7:0] mi,
                              input logic hf, input logic mf, input logic rq, input logic go);
    vec_t v;
    v.start = s; v.btn = b; v.nin = n; v.lanes = ln; v.score = sc; v.miss = mi;
    v.hf = hf; v.mf = mf; v.req = rq; v.go = go;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {4'h0, lanes, score_bcd, misses, hit_flash, miss_flash, note_req, game_over};
  endfunction

  function automatic logic [31:0] expo(input logic [7:0] ln, input logic [7:0] sc,
                                       input logic [7:0] mi, input logic hf, input logic mf,
                                       input logic rq, input logic go);
    return {4'h0, ln, sc, mi, hf, mf, rq, go};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [1:0] b, input logic [1:0] n);
    start = s; button = b; note_in = n;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; start = 1'b0; button = 2'b00; note_in = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  initial begin
    // Scroll of a held lane-0 note stream from the start edge onwards.
    tbl[0]  = mk(1, 2'b00, 2'b01, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[1]  = mk(0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[2]  = mk(0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[3]  = mk(0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[4]  = mk(0, 2'b00, 2'b01, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[5]  = mk(0, 2'b00, 2'b01, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[6]  = mk(0, 2'b00, 2'b01, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[7]  = mk(0, 2'b00, 2'b01, 8'h01, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[8]  = mk(0, 2'b00, 2'b01, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[9]  = mk(0, 2'b00, 2'b01, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[10] = mk(0, 2'b00, 2'b01, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[11] = mk(0, 2'b00, 2'b01, 8'h03, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[12] = mk(0, 2'b00, 2'b01, 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[13] = mk(0, 2'b00, 2'b01, 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[14] = mk(0, 2'b00, 2'b01, 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[15] = mk(0, 2'b00, 2'b01, 8'h07, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[16] = mk(0, 2'b00, 2'b01, 8'h0F, 8'h00, 8'h00, 0, 0, 0, 0);

    // Test 1: reset state and scrolling
    do_reset();
    chk("reset_outputs", outs(), 32'h0);
    for (int k = 0; k < 17; k++) begin
      step(tbl[k].start, tbl[k].btn, tbl[k].nin);
      chk($sformatf("scroll_row%0d", k), outs(),
          expo(tbl[k].lanes, tbl[k].score, tbl[k].miss, tbl[k].hf, tbl[k].mf,
               tbl[k].req, tbl[k].go));
    end

    // Test 2: single lane-1 note hit
    do_reset();
    step(1, 2'b00, 2'b10);
    for (int k = 1; k <= 4; k++) step(0, 2'b00, 2'b10);
    for (int k = 5; k <= 16; k++) step(0, 2'b00, 2'b00);
    chk("hit_lanes_at_strike", 32'(lanes), 32'h80);
    step(0, 2'b10, 2'b00);
    chk("hit_score", 32'(score_bcd), 32'h01);
    chk("hit_flash_set", 32'(hit_flash), 32'h1);
    chk("hit_strike_cleared", 32'(lanes), 32'h00);
    chk("hit_no_miss", 32'(misses), 32'h00);
    step(0, 2'b00, 2'b00);
    step(0, 2'b00, 2'b00);
    chk("hit_flash_hold", 32'(hit_flash), 32'h1);
    step(0, 2'b00, 2'b00);
    chk("hit_flash_clear_on_tick", 32'(hit_flash), 32'h0);

    // Test 3: dropped lane-0 note
    do_reset();
    step(1, 2'b00, 2'b01);
    for (int k = 1; k <= 4; k++) step(0, 2'b00, 2'b01);
    for (int k = 5; k <= 16; k++) step(0, 2'b00, 2'b00);
    chk("drop_lanes_at_strike", 32'(lanes), 32'h08);
    for (int k = 17; k <= 19; k++) step(0, 2'b00, 2'b00);
    chk("drop_no_miss_yet", 32'(misses), 32'h00);
    step(0, 2'b00, 2'b00);
    chk("drop_miss_count", 32'(misses), 32'h01);
    chk("drop_miss_flash", 32'(miss_flash), 32'h1);
    chk("drop_lanes_empty", 32'(lanes), 32'h00);
    for (int k = 21; k <= 23; k++) step(0, 2'b00, 2'b00);
    chk("drop_flash_hold", 32'(miss_flash), 32'h1);
    step(0, 2'b00, 2'b00);
    chk("drop_flash_clear", 32'(miss_flash), 32'h0);
    chk("drop_miss_stays", 32'(misses), 32'h01);

    // Test 4a: double hit in the tick cycle
    do_reset();
    step(1, 2'b00, 2'b11);
    for (int k = 1; k <= 4; k++) step(0, 2'b00, 2'b11);
    for (int k = 5; k <= 16; k++) step(0, 2'b00, 2'b00);
    chk("dual_lanes_at_strike", 32'(lanes), 32'h88);
    for (int k = 17; k <= 19; k++) step(0, 2'b00, 2'b00);
    step(0, 2'b11, 2'b00);
    chk("dual_tick_score", 32'(score_bcd), 32'h02);
    chk("dual_tick_no_miss", 32'(misses), 32'h00);
    chk("dual_tick_hit_flash", 32'(hit_flash), 32'h1);
    chk("dual_tick_miss_flash", 32'(miss_flash), 32'h0);
    chk("dual_tick_lanes", 32'(lanes), 32'h00);

    // Test 4b: BCD carry and saturation
    do_reset();
    step(1, 2'b00, 2'b11);
    for (int k = 1; k <= 16; k++) step(0, 2'b00, 2'b11);
    for (int p = 1; p <= 51; p++) begin
      step(0, 2'b11, 2'b11);
      step(0, 2'b00, 2'b11);
      step(0, 2'b00, 2'b11);
      step(0, 2'b00, 2'b11);
      if (p == 5)  chk("bcd_carry_10", 32'(score_bcd), 32'h10);
      if (p == 49) chk("bcd_98", 32'(score_bcd), 32'h98);
      if (p == 50) chk("bcd_sat_99", 32'(score_bcd), 32'h99);
      if (p == 51) chk("bcd_sat_hold", 32'(score_bcd), 32'h99);
    end
    chk("bcd_no_misses", 32'(misses), 32'h00);

    // Test 5: wrong presses end the game
    do_reset();
    step(1, 2'b00, 2'b10);
    for (int k = 1; k <= 4; k++) step(0, 2'b00, 2'b10);
    for (int k = 5; k <= 16; k++) step(0, 2'b00, 2'b00);
    step(0, 2'b10, 2'b00);
    chk("over_pre_score", 32'(score_bcd), 32'h01);
    step(0, 2'b00, 2'b00);
    step(0, 2'b01, 2'b00);
    chk("wrong_miss1", 32'(misses), 32'h01);
    step(0, 2'b00, 2'b00);
    step(0, 2'b01, 2'b00);
    chk("wrong_miss2", 32'(misses), 32'h02);
    step(0, 2'b00, 2'b00);
    step(0, 2'b01, 2'b00);
    chk("wrong_miss3", 32'(misses), 32'h03);
    chk("over_not_yet", 32'(game_over), 32'h0);
    step(0, 2'b00, 2'b00);
    chk("over_entered", 32'(game_over), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(0, (i % 2 == 1) ? 2'b11 : 2'b00, 2'b11);
      chk($sformatf("over_frozen%0d", i), outs(),
          expo(8'h00, 8'h01, 8'h03, 0, 0, 0, 1));
    end
    step(1, 2'b00, 2'b00);
    chk("restart_cleared", outs(), 32'h0);
    step(0, 2'b00, 2'b00);
    step(0, 2'b00, 2'b00);
    chk("restart_no_req_early", 32'(note_req), 32'h0);
    step(0, 2'b00, 2'b00);
    chk("restart_req_cnt3", 32'(note_req), 32'h1);

    // Test 6: asynchronous reset mid-game
    do_reset();
    step(1, 2'b00, 2'b11);
    for (int k = 1; k <= 16; k++) step(0, 2'b00, 2'b11);
    step(0, 2'b11, 2'b11);
    chk("prereset_state", outs(), expo(8'h77, 8'h02, 8'h00, 1, 0, 0, 0));
    #3;
    n_rst = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'h0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(0, 2'b00, 2'b11);
      chk($sformatf("idle_after_reset%0d", k), outs(), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_highway.md
Name: note_highway

Overview:
- Parametrised successor to the fixed two-lane Guitar Villains game core.
- Scrolls NUM_LANES lanes of LANE_LEN cells toward a strike cell and judges button presses against that cell.
- Keeps a saturating BCD score and a miss counter; runs a small IDLE/PLAY/OVER state machine.
- Sits between the song source, which supplies note_in, and the LED/seven-segment display drivers.

Parameters:
- NUM_LANES, 2, number of note lanes/buttons (1..9).
- LANE_LEN, 7, cells per lane; cell LANE_LEN-1 is the strike cell.
- TICK_DIV, 12000000, clk cycles per scroll step (>=2).
- MAX_MISSES, 5, miss count that ends the game (1..255).
- SCORE_DIGITS, 2, BCD digits of score.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  level; sampled each cycle in IDLE/OVER
- button  in  NUM_LANES  synchronised, active-high, one per lane
- note_in  in  NUM_LANES  note row to inject at next scroll
- note_req  out  1  one-cycle pulse when note_in is consumed
- lanes  out  NUM_LANES*LANE_LEN  lane l occupies bits [l*LANE_LEN +: LANE_LEN]; bit 0 = entry cell
- hit_flash  out  1  high from a hit until the next scroll tick
- miss_flash  out  1  high from a miss until the next scroll tick
- score_bcd  out  4*SCORE_DIGITS  BCD score, digit 0 in the LSBs
- misses  out  8  binary miss count
- game_over  out  1  high in OVER

Behaviour:
- Reset: every register is cleared. This gives state=IDLE, lanes=0, score_bcd=0, misses=0, flashes=0, note_req=0, game_over=0, tick counter=0, button history=0.
- Press detection: press[l] = button[l] & ~btn_q[l], where btn_q is a one-cycle registered copy. btn_q updates in every state.
- IDLE:
  - lanes held at 0; tick counter held at 0.
  - start=1 moves to PLAY next cycle, clearing score, misses and flashes.
- PLAY, tick counter:
  - counts 0..TICK_DIV-1.
  - tick = (count == TICK_DIV-1); the counter wraps to 0 on tick.
- PLAY, per-lane judging in one cycle, using pre-shift lane contents:
  - Hit: press[l] & strike[l]. Strike bit is cleared, score += 1.
  - Wrong press: press[l] & ~strike[l]. One miss.
  - Drop: on tick, strike[l] & ~press[l]. One miss; the note shifts out.
- PLAY, on tick:
  - Each lane shifts toward the strike cell: cell i+1 <= cell i, cell 0 <= note_in[l].
  - note_req=1 for that cycle only.
  - A hit and a tick in the same cycle: the hit is scored and the cleared bit shifts out with no miss.
- Score arithmetic:
  - Per cycle, score += popcount(hits), a value <= 9, added as BCD with ripple carry across digits.
  - Saturates at all-9s; never wraps.
- Miss arithmetic:
  - Per cycle, misses += wrong presses + drops, saturating at 255.
- Flashes:
  - hit_flash set in any cycle with >=1 hit; miss_flash set in any cycle with >=1 miss. Both may be set together.
  - Both clear on the next tick, unless that same cycle sets them again; setting has priority.
- Game-over transition:
  - When the registered misses >= MAX_MISSES, the state goes to OVER on the next clock edge.
  - Events in that cycle are still applied.
- OVER:
  - lanes, score, misses frozen; buttons ignored; note_req=0; game_over=1.
  - start=1 moves to PLAY with lanes, score, misses, flashes and tick counter cleared.
- start is ignored in PLAY.
- Reset asserted mid-game: immediate asynchronous return to the reset values, with no partial update.

Decomposition:
- Package gv_pkg:
  - game_state_t enum {IDLE, PLAY, OVER}, 2-bit.
  - MISS_W=8 constant.
  - bcd_digit_t (logic [3:0]).
- Sub-module bcd_accum: parameter DIGITS. Inputs clk, n_rst, clr, add[3:0]. Output a saturating BCD value.

Test Plan:
All scenarios use NUM_LANES=2, LANE_LEN=4, TICK_DIV=4, MAX_MISSES=3, SCORE_DIGITS=2.
1. Reset then start=1 for one cycle with note_in=2'b01 held. After 4 ticks lane0 = 4'b1111 with its strike bit set; note_req pulses once every 4 cycles.
2. Inject a single note in lane1, then press button[1] while lane1 strike=1. score_bcd=8'h01, hit_flash=1, strike cleared, misses stays 0.
3. Let a lane0 note reach the strike cell with no press, then wait for the tick. misses=1, miss_flash=1 until the following tick.
4. Press both buttons in the cycle where both strike cells are set and tick=1. Score +2 and misses unchanged. Also preload score 8'h98 and hit twice: score saturates at 8'h99.
5. Make wrong presses on an empty strike three times. game_over=1 one cycle after misses reaches 3; later presses and notes are ignored; start returns to PLAY with score 0 and misses 0.
6. Assert n_rst=0 mid-PLAY with lanes populated. All outputs are zero and the state is IDLE before the next clk edge.
